// File: rtl/snoop_req_gen_pkg.sv
// Shared types and constants for the snoop request generator.
// Flag and op encodings, snoop vector field positions, FSM states.
package snoop_req_gen_pkg;

  typedef enum logic [1:0] {
    INVALID      = 2'd0,
    SHARED_CLEAN = 2'd1,
    OWNED_CLEAN  = 2'd2,
    OWNED_DIRTY  = 2'd3
  } flag_e;

  localparam logic RD = 1'b0;
  localparam logic WR = 1'b1;

  localparam int CYCLE_NUM_ADDR = 2;

  localparam int SNP_W        = 14;
  localparam int SNP_MATCH    = 13;
  localparam int SNP_OP       = 12;
  localparam int SNP_HIT_MSB  = 11;
  localparam int SNP_HIT_LSB  = 8;
  localparam int SNP_FLAG_MSB = 7;
  localparam int SNP_FLAG_LSB = 0;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ADDR   = 2'd1,
    S_LOOKUP = 2'd2,
    S_RESP   = 2'd3
  } state_e;

  function automatic logic [2:0] popcnt4(input logic [3:0] v);
    return 3'(v[0]) + 3'(v[1]) + 3'(v[2]) + 3'(v[3]);
  endfunction

endpackage

// File: rtl/snoop_req_gen_if.sv
// Bus address beats in, snoop vector and status out.
// master = bus/control-unit side, slave = snoop front end.
interface snoop_req_gen_if;
  import snoop_req_gen_pkg::*;

  logic             bus_valid;
  logic             bus_op;
  logic [1:0]       bus_src;
  logic [7:0]       bus_addr;
  logic             snp_ack;
  logic [SNP_W-1:0] snp;
  logic             snp_busy;
  logic             addr_abort;
  logic             multi_hit;

  modport master (
    output bus_valid, bus_op, bus_src, bus_addr, snp_ack,
    input  snp, snp_busy, addr_abort, multi_hit
  );

  modport slave (
    input  bus_valid, bus_op, bus_src, bus_addr, snp_ack,
    output snp, snp_busy, addr_abort, multi_hit
  );

endinterface

// File: rtl/snoop_tag_cmp.sv
// 4-way tag/flag compare: hit vector, match and multi-hit.
// en low forces every hit (and therefore match) to zero.
module snoop_tag_cmp
  import snoop_req_gen_pkg::*;
#(
  parameter int TAG_W = 14
) (
  input  logic [TAG_W-1:0]   tag,
  input  logic [4*TAG_W-1:0] tag_vector,
  input  logic [7:0]         flag,
  input  logic               op,
  input  logic               en,
  output logic [3:0]         hit,
  output logic               match,
  output logic               multi
);

  logic [3:0] dirty;

  always_comb begin
    hit   = '0;
    dirty = '0;
    for (int i = 0; i < 4; i++) begin
      hit[i] = en
        && (tag_vector[i*TAG_W +: TAG_W] == tag)
        && (flag[2*i +: 2] != INVALID);
      dirty[i] = hit[i]
        && (flag[2*i +: 2] == OWNED_DIRTY);
    end
  end

  assign match = (op == WR) ? |hit : |dirty;
  assign multi = popcnt4(hit) > 3'd1;

endmodule

// File: rtl/snoop_req_gen.sv
// Snoop front end: two-beat address capture, lookup, held response.
// Optional self-snoop suppression with SNP_SELF_FILTER_EN.
module snoop_req_gen
  import snoop_req_gen_pkg::*;
#(
  parameter int         TAG_W   = 14,
  parameter logic [1:0] CORE_ID = 2'd0
) (
  input  logic               plusclk,
  input  logic               rst,
  snoop_req_gen_if.slave     bus,
  input  logic [4*TAG_W-1:0] tag_vector,
  input  logic [7:0]         flag
);

  state_e state, nxt;

  logic [TAG_W-1:0] tag_q;
  logic             op_q;
  logic [1:0]       src_q;
  logic [SNP_W-1:0] snp_q, snp_d;
  logic             abort_q, abort_d;
  logic             multi_q, multi_d;

  logic [3:0] hit;
  logic       match;
  logic       multi;
  logic       en;

`ifdef SNP_SELF_FILTER_EN
  assign en = (src_q != CORE_ID);
`else
  logic unused_src;
  assign unused_src = ^{src_q, CORE_ID};
  assign en = 1'b1;
`endif

  snoop_tag_cmp #(
    .TAG_W (TAG_W)
  ) u_cmp (
    .tag        (tag_q),
    .tag_vector (tag_vector),
    .flag       (flag),
    .op         (op_q),
    .en         (en),
    .hit        (hit),
    .match      (match),
    .multi      (multi)
  );

  always_ff @(posedge plusclk) begin
    if (rst) state <= S_IDLE;
    else     state <= nxt;
  end

  always_comb begin
    nxt = state;
    unique case (state)
      S_IDLE:   if (bus.bus_valid) nxt = S_ADDR;
      S_ADDR:   nxt = bus.bus_valid ? S_LOOKUP : S_IDLE;
      S_LOOKUP: nxt = S_RESP;
      S_RESP:
        if (!snp_q[SNP_MATCH] || bus.snp_ack)
          nxt = S_IDLE;
      default:  nxt = S_IDLE;
    endcase
  end

  always_comb begin
    snp_d   = snp_q;
    abort_d = 1'b0;
    multi_d = 1'b0;
    unique case (state)
      S_IDLE: snp_d = '0;
      S_ADDR: abort_d = !bus.bus_valid;
      S_LOOKUP: begin
        snp_d[SNP_MATCH] = match;
        snp_d[SNP_OP]    = op_q;
        snp_d[SNP_HIT_MSB:SNP_HIT_LSB]   = hit;
        snp_d[SNP_FLAG_MSB:SNP_FLAG_LSB] = flag;
        multi_d = multi;
      end
      // vector drops to zero on the edge that leaves RESP
      S_RESP: if (nxt == S_IDLE) snp_d = '0;
      default: snp_d = '0;
    endcase
  end

  always_ff @(posedge plusclk) begin
    if (rst) begin
      snp_q   <= '0;
      abort_q <= 1'b0;
      multi_q <= 1'b0;
      tag_q   <= '0;
      op_q    <= 1'b0;
      src_q   <= 2'd0;
    end else begin
      snp_q   <= snp_d;
      abort_q <= abort_d;
      multi_q <= multi_d;
      if (state == S_IDLE && bus.bus_valid) begin
        tag_q[TAG_W-1 -: 8] <= bus.bus_addr;
        op_q  <= bus.bus_op;
        src_q <= bus.bus_src;
      end
      // offset bits of beat 2 are not part of the tag
      if (state == S_ADDR && bus.bus_valid)
        tag_q[TAG_W-9:0] <= bus.bus_addr[7 -: TAG_W-8];
    end
  end

  assign bus.snp        = snp_q;
  assign bus.snp_busy   = (state != S_IDLE);
  assign bus.addr_abort = abort_q;
  assign bus.multi_hit  = multi_q;

endmodule

// File: tb/tb_snoop_req_gen.sv
// Directed bench for snoop_req_gen with a transaction-level model.
// Build with or without SNP_SELF_FILTER_EN.
module tb_snoop_req_gen;

`ifdef SNP_SELF_FILTER_EN
  localparam bit SELF_FILT = 1'b1;
`else
  localparam bit SELF_FILT = 1'b0;
`endif

  logic        clk;
  logic        rst;
  logic [55:0] tv;
  logic [7:0]  fl;

  snoop_req_gen_if sif ();

  snoop_req_gen #(
    .TAG_W   (14),
    .CORE_ID (2'd0)
  ) dut (
    .plusclk    (clk),
    .rst        (rst),
    .bus        (sif.slave),
    .tag_vector (tv),
    .flag       (fl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  bit          chk_en = 1'b0;
  logic [13:0] exp_snp;
  logic        exp_busy, exp_abort, exp_multi;
  bit          pin_en = 1'b0;
  logic [13:0] pin_snp;

  always @(negedge clk) begin
    if (chk_en) begin
      checks++;
      if (sif.snp !== exp_snp) begin
        errors++;
        $display("FAIL snp got %b want %b at %0t", sif.snp, exp_snp, $time);
      end
      checks++;
      if (sif.snp_busy !== exp_busy) begin
        errors++;
        $display("FAIL snp_busy got %b want %b at %0t", sif.snp_busy, exp_busy, $time);
      end
      checks++;
      if (sif.addr_abort !== exp_abort) begin
        errors++;
        $display("FAIL addr_abort got %b want %b at %0t", sif.addr_abort, exp_abort, $time);
      end
      checks++;
      if (sif.multi_hit !== exp_multi) begin
        errors++;
        $display("FAIL multi_hit got %b want %b at %0t", sif.multi_hit, exp_multi, $time);
      end
      if (pin_en) begin
        checks++;
        if (exp_snp !== pin_snp) begin
          errors++;
          $display("FAIL model_pin got %b want %b at %0t", exp_snp, pin_snp, $time);
        end
      end
    end
  end

  // What the snoop vector must be for one transaction, from the block rules.
  function automatic logic [13:0] model_snp(
    input logic op, input logic [1:0] src, input logic [15:0] addr,
    input logic [55:0] t, input logic [7:0] f, output logic mh);
    logic [3:0] h;
    logic m;
    int n;
    h = '0; m = 1'b0; n = 0;
    for (int i = 0; i < 4; i++)
      if (f[2*i +: 2] != 2'd0 && t[i*14 +: 14] == addr[15:2]) h[i] = 1'b1;
    if (SELF_FILT && src == 2'd0) h = '0;
    for (int i = 0; i < 4; i++)
      if (h[i]) begin
        n++;
        if (op || f[2*i +: 2] == 2'd3) m = 1'b1;
      end
    mh = (n > 1);
    return {m, op, h, f};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
    pin_en = 1'b0;
  endtask

  task automatic expect_out(input logic [13:0] s, input logic b,
                            input logic a, input logic m);
    exp_snp = s; exp_busy = b; exp_abort = a; exp_multi = m;
  endtask

  task automatic noise();
    tv = 56'({$urandom, $urandom});
    fl = 8'($urandom);
    sif.bus_addr = 8'($urandom);
  endtask

  task automatic run_txn(input logic op, input logic [1:0] src,
    input logic [15:0] addr, input logic [55:0] t, input logic [7:0] f,
    input bit drop, input int ack_d, input bit use_pin, input logic [13:0] pin);
    logic [13:0] e;
    logic mh;
    e = model_snp(op, src, addr, t, f, mh);
    noise();
    sif.bus_valid = 1'b1; sif.bus_op = op; sif.bus_src = src;
    sif.bus_addr = addr[15:8]; sif.snp_ack = 1'b0;
    expect_out('0, 1'b0, 1'b0, 1'b0);
    step();
    noise();
    sif.snp_ack = 1'b1; sif.bus_op = ~op; sif.bus_src = ~src;
    if (drop) begin
      sif.bus_valid = 1'b0;
      expect_out('0, 1'b1, 1'b0, 1'b0);
      step();
      sif.snp_ack = 1'b0;
      expect_out('0, 1'b0, 1'b1, 1'b0);
      step();
      expect_out('0, 1'b0, 1'b0, 1'b0);
      step();
      return;
    end
    sif.bus_valid = 1'b1; sif.bus_addr = addr[7:0];
    expect_out('0, 1'b1, 1'b0, 1'b0);
    step();
    sif.bus_addr = 8'($urandom); tv = t; fl = f;
    expect_out('0, 1'b1, 1'b0, 1'b0);
    step();
    if (!e[13]) begin
      noise();
      sif.snp_ack = 1'b0;
      expect_out(e, 1'b1, 1'b0, mh);
      pin_en = use_pin; pin_snp = pin;
      step();
    end else begin
      for (int c = 0; c <= ack_d; c++) begin
        noise();
        sif.snp_ack = (c == ack_d);
        expect_out(e, 1'b1, 1'b0, (c == 0) ? mh : 1'b0);
        pin_en = use_pin && (c == 0); pin_snp = pin;
        step();
      end
    end
    noise();
    sif.bus_valid = 1'b0; sif.snp_ack = 1'b0;
    expect_out('0, 1'b0, 1'b0, 1'b0);
    step();
  endtask

  initial begin
    logic [15:0] ra;
    logic [55:0] rt;
    rst = 1'b1;
    tv = '0; fl = '0;
    sif.bus_valid = 1'b0; sif.bus_op = 1'b0; sif.bus_src = 2'd0;
    sif.bus_addr = '0; sif.snp_ack = 1'b0;
    exp_snp = '0; exp_busy = 1'b0; exp_abort = 1'b0; exp_multi = 1'b0;
    step();
    chk_en = 1'b1;
    step();
    rst = 1'b0;
    step();

    // RD, dirty hit in block 0, ack after 2 extra cycles
    run_txn(1'b0, 2'd1, 16'hA5C4,
      {14'h0003, 14'h0002, 14'h0001, 14'h2971}, 8'b11010111,
      1'b0, 2, 1'b1, 14'b10_0001_1101_0111);
    // RD, shared-clean hit in block 1: one-cycle response
    run_txn(1'b0, 2'd2, 16'h1238,
      {14'h0000, 14'h0000, 14'h048E, 14'h0005}, 8'b00000100,
      1'b0, 0, 1'b1, 14'b00_0010_0000_0100);
    // WR, owned-clean hit in block 2, ack 5 cycles later
    run_txn(1'b1, 2'd3, 16'hFFFF,
      {14'h0000, 14'h3FFF, 14'h0000, 14'h0000}, 8'b00100000,
      1'b0, 5, 1'b1, 14'b11_0100_0010_0000);
    // missing beat 2
    run_txn(1'b0, 2'd1, 16'hA5C4,
      {14'h0003, 14'h0002, 14'h0001, 14'h2971}, 8'b11010111,
      1'b1, 0, 1'b0, '0);
    // blocks 0 and 3 share a tag
    run_txn(1'b0, 2'd1, 16'h0010,
      {14'h0004, 14'h0002, 14'h0001, 14'h0004}, 8'b10000001,
      1'b0, 0, 1'b1, 14'b00_1001_1000_0001);
    // WR to an invalid block only
    run_txn(1'b1, 2'd2, 16'h4000,
      {14'h0003, 14'h0002, 14'h1000, 14'h0001}, 8'b11110011,
      1'b0, 0, 1'b1, 14'b01_0000_1111_0011);
    // own transaction, dirty hit, ack in first response cycle
    run_txn(1'b0, 2'd0, 16'hA5C4,
      {14'h0003, 14'h0002, 14'h0001, 14'h2971}, 8'b00000011,
      1'b0, 0, 1'b1,
      SELF_FILT ? 14'b00_0000_0000_0011 : 14'b10_0001_0000_0011);

    // reset asserted while in ADDR
    sif.bus_valid = 1'b1; sif.bus_op = 1'b1; sif.bus_src = 2'd1;
    sif.bus_addr = 8'hA5;
    expect_out('0, 1'b0, 1'b0, 1'b0);
    step();
    rst = 1'b1; sif.bus_addr = 8'hC4;
    expect_out('0, 1'b1, 1'b0, 1'b0);
    step();
    rst = 1'b0; sif.bus_valid = 1'b0;
    expect_out('0, 1'b0, 1'b0, 1'b0);
    step();
    step();

    for (int k = 0; k < 8; k++) begin
      ra = 16'($urandom);
      rt = 56'({$urandom, $urandom});
      rt[($urandom_range(0, 3))*14 +: 14] = ra[15:2];
      run_txn(1'($urandom), 2'($urandom), ra, rt, 8'($urandom),
        1'b0, int'($urandom_range(0, 3)), 1'b0, '0);
    end

    chk_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
